div_sequencer: RTL and testbench

//  Front-end controller for the 32-cycle restoring divider core (RISC-V M: DIV/DIVU/REM/REMU).

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_special_case.sv | 38 +++
 rtl/div_sequencer.sv | 143 ++++++++++++++
 tb/tb_div_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider front-end: op decode bits, FSM states
// and the RISC-V special-case result constants.
package div_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int ITERATIONS_DEF = 32;
  localparam int CNT_W_DEF      = 6;

  // funct3 decode: bit 1 selects remainder, bit 0 selects unsigned; bit 2 is ignored
  localparam int F3_REM_BIT      = 1;
  localparam int F3_UNSIGNED_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [XLEN_DEF-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [XLEN_DEF-1:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/div_special_case.sv
// Detects divide-by-zero and signed overflow, and produces the architectural
// result for those cases so the core never has to be started for them.
module div_special_case
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            is_special,
  output logic [XLEN-1:0] special_result
);

  logic is_rem;
  logic is_signed;
  logic div_zero;
  logic overflow;
  logic unused_f3;

  assign unused_f3 = funct3[2];
  assign is_rem    = funct3[F3_REM_BIT];
  assign is_signed = ~funct3[F3_UNSIGNED_BIT];

  // Classify the request and pick the fixed result; div-by-zero dominates overflow
  always_comb begin
    div_zero       = (rs2 == '0);
    overflow       = is_signed && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
    is_special     = div_zero || overflow;
    special_result = '0;
    if (div_zero) begin
      special_result = is_rem ? rs1 : ALL_ONES;
    end else if (overflow) begin
      special_result = is_rem ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Front-end controller for the iterative restoring divider: accepts a request,
// resolves special cases locally, otherwise sequences the core and holds the
// selected quotient/remainder until downstream takes it.
module div_sequencer
  import div_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ITERATIONS = ITERATIONS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstlow,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  output logic [XLEN-1:0]  core_a,
  output logic [XLEN-1:0]  core_b,
  output logic             core_sgn,
  output logic             core_start,
  output logic [CNT_W-1:0] core_count,
  input  logic             core_busy,
  input  logic [XLEN-1:0]  core_q,
  input  logic [XLEN-1:0]  core_r,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [XLEN-1:0]  result
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ITERATIONS);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sgn_q, sgn_d;
  logic              rem_q, rem_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_special;
  logic [XLEN-1:0]   special_result;
  logic              accept;
  logic              capture;

  div_special_case #(
    .XLEN (XLEN)
  ) u_special (
    .rs1            (rs1),
    .rs2            (rs2),
    .funct3         (funct3),
    .is_special     (is_special),
    .special_result (special_result)
  );

  assign ready_in   = (state_q == S_IDLE) && rstlow;
  assign core_start = (state_q == S_START);
  assign valid_out  = (state_q == S_DONE);
  assign core_count = count_q;
  assign core_a     = a_q;
  assign core_b     = b_q;
  assign core_sgn   = sgn_q;
  assign result     = result_q;

  // Next-state, operand latch, counter and result selection; flush overrides everything
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    rem_d    = rem_q;
    count_d  = '0;
    result_d = result_q;
    // a flushed request is never taken, so operands stay put on flush
    accept   = valid_in && ready_in && !flush;
    capture  = (state_q == S_RUN) && (count_q == CNT_MAX) && !core_busy;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d   = rs1;
          b_d   = rs2;
          sgn_d = ~funct3[F3_UNSIGNED_BIT];
          rem_d = funct3[F3_REM_BIT];
          if (is_special) begin
            result_d = special_result;
            state_d  = S_DONE;
          end else begin
            state_d  = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (capture) begin
          result_d = rem_q ? core_r : core_q;
          state_d  = S_DONE;
        end else if (count_q == CNT_MAX) begin
          count_d = count_q;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (ready_out) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d  = S_IDLE;
      count_d  = '0;
      result_d = result_q;
    end
  end

  // State, operand and result registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstlow) begin
    if (!rstlow) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      rem_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a simple behavioural divider core.
module tb_div_sequencer;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  logic             clk;
  logic             rstlow;
  logic             flush;
  logic             valid_in;
  logic             ready_in;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [XLEN-1:0]  core_a;
  logic [XLEN-1:0]  core_b;
  logic             core_sgn;
  logic             core_start;
  logic [CNT_W-1:0] core_count;
  logic             core_busy;
  logic [XLEN-1:0]  core_q;
  logic [XLEN-1:0]  core_r;
  logic             valid_out;
  logic             ready_out;
  logic [XLEN-1:0]  result;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic started;
  logic stall;

  div_sequencer #(.XLEN(XLEN), .ITERATIONS(ITER), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstlow     (rstlow),
    .flush      (flush),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_sgn   (core_sgn),
    .core_start (core_start),
    .core_count (core_count),
    .core_busy  (core_busy),
    .core_q     (core_q),
    .core_r     (core_r),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: busy from start until the count reaches ITER, plus optional stall
  always @(posedge clk or negedge rstlow) begin
    if (!rstlow) started <= 1'b0;
    else if (core_start) started <= 1'b1;
    else if (flush || core_count == CNT_W'(ITER)) started <= 1'b0;
  end

  always @(posedge clk) if (core_start === 1'b1) starts++;

  always_comb begin
    core_busy = stall || (started && (core_count < CNT_W'(ITER)));
    core_q = '0;
    core_r = core_a;
    if (core_b != '0) begin
      if (core_sgn && core_a == 32'h8000_0000 && core_b == 32'hFFFF_FFFF) begin
        core_q = core_a;
        core_r = '0;
      end else if (core_sgn) begin
        core_q = $signed(core_a) / $signed(core_b);
        core_r = $signed(core_a) % $signed(core_b);
      end else begin
        core_q = core_a / core_b;
        core_r = core_a % core_b;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; it is accepted on the following posedge
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3   = f;
    rs1      = a;
    rs2      = b;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Count negedges after the accept edge until valid_out is seen (bounded)
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_out && n < 100);
  endtask

  // Full transaction with ready_out high: latency, result, single-cycle valid, start count
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int exp_starts);
    int n;
    int s0;
    s0 = starts;
    send(f, a, b);
    wait_valid(n);
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, result, exp);
    @(negedge clk);
    check({tag, "_vld_drop"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_starts"}, starts - s0, exp_starts);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    rstlow    = 1'b0;
    flush     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    stall     = 1'b0;
    funct3    = 3'b000;
    rs1       = '0;
    rs2       = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_low", {31'd0, ready_in}, 32'd0);
    rstlow = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, ready_in}, 32'd1);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_count", {26'd0, core_count}, 32'd0);
    check("rst_start", {31'd0, core_start}, 32'd0);
    check("rst_core_a", core_a, 32'd0);

    // Core path, unsigned and signed
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, ITER + 3, 1);
    check("divu_sgn", {31'd0, core_sgn}, 32'd0);
    check("divu_core_a", core_a, 32'd100);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, ITER + 3, 1);
    check("rem_sgn", {31'd0, core_sgn}, 32'd1);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, ITER + 3, 1);

    // Special cases: no core start, one-cycle latency
    run_op("div_x_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_1234_0", 3'b111, 32'h1234, 32'd0, 32'h1234, 1, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, ITER + 3, 1);

    // Backpressure: DONE held for 10 cycles while a new request waits
    ready_out = 1'b0;
    send(3'b101, 32'd20, 32'd3);
    wait_valid(n);
    check("hold_lat", n, ITER + 3);
    valid_in = 1'b1;
    funct3   = 3'b101;
    rs1      = 32'd77;
    rs2      = 32'd11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, valid_out}, 32'd1);
      check("hold_result", result, 32'd6);
      check("hold_ready_in", {31'd0, ready_in}, 32'd0);
    end
    check("hold_core_a", core_a, 32'd20);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
    check("hold_release", {31'd0, valid_out}, 32'd0);
    check("hold_idle", {31'd0, ready_in}, 32'd1);

    // Flush at RUN count 10
    send(3'b101, 32'd1000, 32'd10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_count != 6'd10 && n < 60);
    check("flush_reach10", {26'd0, core_count}, 32'd10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {31'd0, ready_in}, 32'd1);
    check("flush_count", {26'd0, core_count}, 32'd0);
    check("flush_result", result, 32'd6);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_out) n++;
    end
    check("flush_no_valid", n, 0);
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, ITER + 3, 1);

    // Flush beats a simultaneous accept
    held = starts;
    @(negedge clk);
    valid_in = 1'b1;
    funct3   = 3'b101;
    rs1      = 32'd55;
    rs2      = 32'd5;
    flush    = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    flush    = 1'b0;
    check("flush_acc_core_a", core_a, 32'd9);
    check("flush_acc_ready", {31'd0, ready_in}, 32'd1);
    repeat (3) @(negedge clk);
    check("flush_acc_starts", starts - held, 32'd0);

    // Capture waits for core_busy to drop
    stall = 1'b1;
    send(3'b101, 32'd50, 32'd5);
    repeat (40) @(negedge clk);
    check("stall_no_valid", {31'd0, valid_out}, 32'd0);
    check("stall_count_sat", {26'd0, core_count}, ITER);
    stall = 1'b0;
    @(negedge clk);
    check("stall_valid", {31'd0, valid_out}, 32'd1);
    check("stall_result", result, 32'd10);
    @(negedge clk);

    // Asynchronous reset mid-RUN
    send(3'b100, 32'd1234, 32'd7);
    repeat (8) @(negedge clk);
    #2 rstlow = 1'b0;
    #1;
    check("arst_count", {26'd0, core_count}, 32'd0);
    check("arst_core_a", core_a, 32'd0);
    check("arst_core_b", core_b, 32'd0);
    check("arst_sgn", {31'd0, core_sgn}, 32'd0);
    check("arst_start", {31'd0, core_start}, 32'd0);
    check("arst_valid", {31'd0, valid_out}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rstlow = 1'b1;
    @(negedge clk);
    check("arst_ready", {31'd0, ready_in}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
